// File: rtl/key_event.sv
// key_event: keypad front end for the calculator datapath.
// Synchronizes the 20 raw push-button lines, debounces presses and
// releases, and rejects multi-key chords. Each accepted press yields one
// single-cycle strobe with a stable keycode.
//
// Optional build macro: KEY_EVENT_REPEAT_EN adds auto-repeat while a key is
// held. The delay before the first repeat is REPEAT_DELAY cycles and the
// interval between later repeats is REPEAT_RATE cycles. Keys 0..16 repeat.
// Keys 17..19 never repeat. Without the macro, every press gives exactly
// one strobe.
//
// Ports:
//   hz100    in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   pb       in   20 raw asynchronous button lines, active-high
//   keycode  out  index of the accepted key, held between strobes
//   strobe   out  one-cycle pulse per accepted key event
//   pressed  out  high while a debounced key is held
//   multi    out  sticky chord flag, cleared when a release completes
module key_event #(
   parameter int unsigned DEBOUNCE     = 4,
   parameter int unsigned REPEAT_DELAY = 50,
   parameter int unsigned REPEAT_RATE  = 10
) (
   input  logic        hz100,
   input  logic        reset_n,
   input  logic [19:0] pb,
   output logic [4:0]  keycode,
   output logic        strobe,
   output logic        pressed,
   output logic        multi
);

   localparam int unsigned NKEYS = 20;
   localparam int unsigned KW    = 5;
   localparam int unsigned CW    = 8;

   localparam logic [CW-1:0] DB_LIMIT = CW'(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   // Two-flop synchronizer. Only s2 is used downstream.
   logic [NKEYS-1:0] s1;
   logic [NKEYS-1:0] s2;

   // Decode of the synchronized lines.
   logic [KW-1:0] code;
   logic          one;
   logic          none;
   logic          many;

   // FSM state and datapath registers.
   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [KW-1:0] cand;
   logic [KW-1:0] cand_n;
   logic [KW-1:0] keycode_n;
   logic          strobe_n;
   logic          pressed_n;
   logic          multi_n;

`ifdef KEY_EVENT_REPEAT_EN
   localparam int unsigned HW = 16;

   localparam logic [HW-1:0] REP_DELAY       = HW'(REPEAT_DELAY);
   localparam logic [HW-1:0] REP_RATE        = HW'(REPEAT_RATE);
   localparam logic [KW-1:0] LAST_REPEAT_KEY = KW'(16);

   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_cnt_n;
   // rep_phase is set once the first repeat has fired. After that,
   // hold_cnt measures REPEAT_RATE instead of REPEAT_DELAY.
   logic          rep_phase;
   logic          rep_phase_n;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

   // Input synchronizer.
   always_ff @(posedge hz100 or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= pb;
         s2 <= s1;
      end
   end

   // Encode the set bit. The result is only meaningful when exactly one
   // bit is set.
   always_comb begin
      code = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (s2[i]) begin
            code = KW'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves something only when two or more
   // bits are set.
   assign none = (s2 == '0);
   assign many = ((s2 & (s2 - NKEYS'(1))) != '0);
   assign one  = !none && !many;

   // Next-state and output logic.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      cand_n    = cand;
      keycode_n = keycode;
      strobe_n  = 1'b0;
      multi_n   = multi;
`ifdef KEY_EVENT_REPEAT_EN
      hold_cnt_n  = hold_cnt;
      rep_phase_n = rep_phase;
`endif

      unique case (state)
         ST_IDLE: begin
            if (one) begin
               state_n = ST_DEBOUNCE;
               cand_n  = code;
               cnt_n   = CW'(1);
            end else if (many) begin
               state_n = ST_RELEASE;
               multi_n = 1'b1;
               cnt_n   = '0;
            end
         end

         ST_DEBOUNCE: begin
            if (many) begin
               state_n = ST_RELEASE;
               multi_n = 1'b1;
               cnt_n   = '0;
            end else if (none) begin
               state_n = ST_IDLE;
            end else if (code != cand) begin
               // A different key restarts the stability count.
               cand_n = code;
               cnt_n  = CW'(1);
            end else if (cnt == DB_LIMIT) begin
               state_n   = ST_HELD;
               keycode_n = cand;
               strobe_n  = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
               hold_cnt_n  = '0;
               rep_phase_n = 1'b0;
`endif
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         ST_HELD: begin
            if (none) begin
               // The first released cycle counts toward the release debounce.
               state_n = ST_RELEASE;
               cnt_n   = CW'(1);
            end else if (many || (code != cand)) begin
               state_n = ST_RELEASE;
               multi_n = 1'b1;
               cnt_n   = '0;
            end else begin
`ifdef KEY_EVENT_REPEAT_EN
               // Only keys 0..16 auto-repeat. The operator and equals keys
               // give exactly one event per press.
               if (cand <= LAST_REPEAT_KEY) begin
                  hold_cnt_n = hold_cnt + HW'(1);
                  if (!rep_phase && (hold_cnt_n == REP_DELAY)) begin
                     strobe_n    = 1'b1;
                     rep_phase_n = 1'b1;
                     hold_cnt_n  = '0;
                  end else if (rep_phase && (hold_cnt_n == REP_RATE)) begin
                     strobe_n   = 1'b1;
                     hold_cnt_n = '0;
                  end
               end
`endif
            end
         end

         ST_RELEASE: begin
            if (!none) begin
               // Any activity restarts the release. A full clean release
               // must complete before a new press can be accepted.
               cnt_n = '0;
            end else if (cnt == DB_LIMIT) begin
               state_n = ST_IDLE;
               multi_n = 1'b0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase

      pressed_n = (state_n == ST_HELD);
   end

   // State and output registers.
   always_ff @(posedge hz100 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         cand    <= '0;
         keycode <= '0;
         strobe  <= 1'b0;
         pressed <= 1'b0;
         multi   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         cand    <= cand_n;
         keycode <= keycode_n;
         strobe  <= strobe_n;
         pressed <= pressed_n;
         multi   <= multi_n;
      end
   end

`ifdef KEY_EVENT_REPEAT_EN
   // Auto-repeat hold counter.
   always_ff @(posedge hz100 or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt  <= '0;
         rep_phase <= 1'b0;
      end else begin
         hold_cnt  <= hold_cnt_n;
         rep_phase <= rep_phase_n;
      end
   end
`endif

endmodule

// File: tb/tb_key_event.sv
// Testbench for key_event. It runs directed key sequences and compares the
// DUT on every cycle with a run-length model of the keypad rules. It also
// checks a set of hand-computed expectations for strobe timing and counts.
module tb_key_event;

   localparam int DB = 4;
   localparam int RD = 50;
   localparam int RR = 10;

   logic        hz100 = 1'b0;
   logic        reset_n;
   logic [19:0] pb;
   logic [4:0]  keycode;
   logic        strobe;
   logic        pressed;
   logic        multi;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit model_on = 1'b0;

   key_event #(
      .DEBOUNCE     (DB),
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR)
   ) dut (
      .hz100   (hz100),
      .reset_n (reset_n),
      .pb      (pb),
      .keycode (keycode),
      .strobe  (strobe),
      .pressed (pressed),
      .multi   (multi)
   );

   always #5 hz100 = ~hz100;

   always @(posedge hz100) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model. The phases are armed, held and released.
   //   Armed:    a press is accepted once the same single key has been seen
   //             for DB+1 consecutive synchronized cycles.
   //   Held:     the press is active and pressed is high.
   //   Released: the model re-arms after DB+1 consecutive all-clear cycles.
   logic [19:0] m_s1;
   logic [19:0] m_s2;
   int          m_phase;
   int          run_key;
   int          run_len;
   int          zero_run;
   int          hold_cyc;
   logic [4:0]  e_key;
   logic        e_strobe;
   logic        e_pressed;
   logic        e_multi;

   always @(posedge hz100 or negedge reset_n) begin
      int nset;
      int k;
      if (!reset_n) begin
         m_s1 = '0; m_s2 = '0; m_phase = 0; run_key = -1; run_len = 0;
         zero_run = 0; hold_cyc = 0;
         e_key = '0; e_strobe = 1'b0; e_pressed = 1'b0; e_multi = 1'b0;
      end else begin
         nset = $countones(m_s2);
         k = -1;
         for (int i = 0; i < 20; i++) if (m_s2[i]) k = i;
         e_strobe = 1'b0;
         case (m_phase)
            0: begin
               if (nset == 1) begin
                  if (k == run_key) run_len++;
                  else begin run_key = k; run_len = 1; end
                  if (run_len == DB + 1) begin
                     e_strobe = 1'b1; e_key = 5'(k); m_phase = 1; hold_cyc = 0;
                  end
               end else if (nset == 0) begin
                  run_len = 0; run_key = -1;
               end else begin
                  m_phase = 2; e_multi = 1'b1; zero_run = 0;
               end
            end
            1: begin
               if (nset == 1 && k == int'(e_key)) begin
                  hold_cyc++;
`ifdef KEY_EVENT_REPEAT_EN
                  if (k <= 16 && (hold_cyc == RD ||
                      (hold_cyc > RD && (hold_cyc - RD) % RR == 0)))
                     e_strobe = 1'b1;
`endif
               end else if (nset == 0) begin
                  m_phase = 2; zero_run = 1;
               end else begin
                  m_phase = 2; e_multi = 1'b1; zero_run = 0;
               end
            end
            default: begin
               if (nset == 0) begin
                  zero_run++;
                  if (zero_run == DB + 1) begin
                     m_phase = 0; e_multi = 1'b0; run_key = -1; run_len = 0;
                  end
               end else begin
                  zero_run = 0;
               end
            end
         endcase
         e_pressed = (m_phase == 1);
         m_s2 = m_s1;
         m_s1 = pb;
      end
   end

   // Compare the DUT outputs against the model on every cycle.
   always @(negedge hz100) begin
      if (model_on) begin
         check("strobe",  int'(strobe),  int'(e_strobe));
         check("keycode", int'(keycode), int'(e_key));
         check("pressed", int'(pressed), int'(e_pressed));
         check("multi",   int'(multi),   int'(e_multi));
      end
   end

   // Count strobes and record when the last one was seen.
   int n_strobe = 0;
   int last_strobe_cyc = -1;
   always @(negedge hz100) begin
      if (strobe === 1'b1) begin
         n_strobe++;
         last_strobe_cyc = cyc;
      end
   end

   // Drive v from the current negedge for n cycles.
   task automatic hold(input logic [19:0] v, input int n);
      pb = v;
      repeat (n) @(negedge hz100);
   endtask

   function automatic logic [19:0] key(input int i);
      logic [19:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int t1;
      int seq7 [7];
      bit seen;
      seq7 = '{1, 0, 1, 1, 1, 1, 1};
      pb = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge hz100);
      check("rst_strobe",  int'(strobe),  0);
      check("rst_keycode", int'(keycode), 0);
      check("rst_pressed", int'(pressed), 0);
      check("rst_multi",   int'(multi),   0);
      reset_n = 1'b1;
      model_on = 1'b1;

      // Idle input: no events.
      hold('0, 20);
      check("idle_strobes", n_strobe, 0);
      check("idle_multi", int'(multi), 0);

      // Clean press of key 5. The strobe comes 2+DB cycles after the first
      // edge that samples the key.
      n_strobe = 0;
      t0 = cyc;
      hold(key(5), 10);
      check("k5_strobes", n_strobe, 1);
      check("k5_latency", last_strobe_cyc - (t0 + 1), 6);
      check("k5_keycode", int'(keycode), 5);
      t1 = cyc;
      pb = '0;
      repeat (2) @(negedge hz100);
      check("k5_pressed_hold", int'(pressed), 1);
      @(negedge hz100);
      check("k5_pressed_fall", int'(pressed), 0);
      check("k5_fall_time", cyc - t1, 3);
      hold('0, 8);

      // A glitch on key 7 restarts the debounce count.
      n_strobe = 0;
      t0 = cyc;
      foreach (seq7[i]) hold(seq7[i] != 0 ? key(7) : 20'h0, 1);
      hold(key(7), 3);
      check("k7_strobes", n_strobe, 1);
      check("k7_restart_time", last_strobe_cyc, t0 + 9);
      check("k7_keycode", int'(keycode), 7);
      hold('0, 10);

      // Chord of keys 3 and 9: no strobe, multi sticky until release completes.
      n_strobe = 0;
      hold(key(3) | key(9), 8);
      check("chord_strobes", n_strobe, 0);
      check("chord_multi", int'(multi), 1);
      t1 = cyc;
      pb = '0;
      repeat (6) @(negedge hz100);
      check("chord_multi_hold", int'(multi), 1);
      @(negedge hz100);
      check("chord_multi_clear", int'(multi), 0);
      check("chord_clear_time", cyc - t1, 7);
      hold(key(9), 8);
      check("k9_strobes", n_strobe, 1);
      check("k9_keycode", int'(keycode), 9);
      hold('0, 10);

      // Reset asserted during the strobe cycle of key 2.
      n_strobe = 0;
      pb = key(2);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge hz100);
         if (strobe === 1'b1) seen = 1'b1;
      end
      check("k2_first_strobe_seen", int'(seen), 1);
      #2 reset_n = 1'b0;
      #1;
      check("k2_rst_strobe",  int'(strobe),  0);
      check("k2_rst_pressed", int'(pressed), 0);
      check("k2_rst_keycode", int'(keycode), 0);
      #1 reset_n = 1'b1;
      t1 = cyc;
      repeat (10) @(negedge hz100);
      check("k2_strobes", n_strobe, 2);
      check("k2_restrobe_time", last_strobe_cyc, t1 + 7);
      check("k2_keycode", int'(keycode), 2);
      hold('0, 10);

      // A second key joins while key 4 is held: the event is dropped and
      // multi is raised.
      n_strobe = 0;
      hold(key(4), 8);
      hold(key(4) | key(6), 4);
      check("held_chord_multi", int'(multi), 1);
      check("held_chord_pressed", int'(pressed), 0);
      hold(key(6), 6);
      check("held_chord_strobes", n_strobe, 1);
      hold('0, 8);
      check("held_chord_clear", int'(multi), 0);

      // Long hold of backspace (16): repeats only when the feature is built in.
      n_strobe = 0;
      hold(key(16), 100);
      hold('0, 12);
`ifdef KEY_EVENT_REPEAT_EN
      check("k16_strobes", n_strobe, 6);
`else
      check("k16_strobes", n_strobe, 1);
`endif
      check("k16_keycode", int'(keycode), 16);

      // Long hold of equals (19): never repeats.
      n_strobe = 0;
      hold(key(19), 100);
      hold('0, 12);
      check("k19_strobes", n_strobe, 1);
      check("k19_keycode", int'(keycode), 19);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
